// File: rtl/prefetcher_pkg.sv
// Shared types for the prefetcher data block and the stride detector.
//   data_opcode_e : opcodes understood by the prefetcher data block.
//   det_state_e   : stride detector FSM states.
//   eff_threshold : maps a programmed confidence threshold to its effective value.
package prefetcher_pkg;

  typedef enum logic [2:0] {
    readReqPref     = 3'd1,
    readReqMaster   = 3'd2,
    readDataSlave   = 3'd3,
    readDataPromise = 3'd4
  } data_opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StTrain,
    StLocked,
    StDrain
  } det_state_e;

  localparam int unsigned   ConfWidth = 2;
  localparam logic [1:0]    ConfMax   = 2'd3;

  // A programmed threshold of zero behaves like one.
  function automatic logic [1:0] eff_threshold(input logic [1:0] thr);
    return (thr == 2'd0) ? 2'd1 : thr;
  endfunction

endpackage

// File: rtl/prefetch_stride_calc.sv
// Combinational delta / stride comparison for the stride detector.
//   obs_addr_i  : address of the observed master read
//   last_addr_i : previously observed address
//   stride_i    : currently trained signed stride
//   delta_o     : obs_addr_i - last_addr_i truncated to the stride width
//   in_range_o  : delta is nonzero and representable in STRIDE_WIDTH signed bits
//   match_o     : delta is in range and equals stride_i
module prefetch_stride_calc
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 64,
  parameter int unsigned STRIDE_WIDTH = 16
) (
  input  logic        [ADDR_BITS-1:0]    obs_addr_i,
  input  logic        [ADDR_BITS-1:0]    last_addr_i,
  input  logic signed [STRIDE_WIDTH-1:0] stride_i,
  output logic signed [STRIDE_WIDTH-1:0] delta_o,
  output logic                           in_range_o,
  output logic                           match_o
);

  logic [ADDR_BITS-1:0]            delta_full;
  // Bits that must all equal the stride sign bit for the delta to fit.
  logic [ADDR_BITS-STRIDE_WIDTH:0] upper;

  always_comb begin
    delta_full = obs_addr_i - last_addr_i;
    upper      = delta_full[ADDR_BITS-1:STRIDE_WIDTH-1];
    delta_o    = delta_full[STRIDE_WIDTH-1:0];
    in_range_o = (delta_full != '0) && ((&upper) || !(|upper));
    match_o    = in_range_o && (delta_o == stride_i);
  end

endmodule

// File: rtl/prefetch_stride_detector.sv
// Stride detector feeding the prefetcher data block.
// Watches master read addresses, trains a signed stride with a confidence counter and,
// once locked, issues prefetch requests along that stride under a valid/ready handshake.
//   clk, resetN            : clock, asynchronous active-low reset
//   obs_valid, obs_addr    : observed master read
//   crs_enable             : detector enable
//   crs_confThreshold      : matching deltas required to lock (0 behaves as 1)
//   crs_prefetchDepth      : max outstanding unrequested prefetches
//   prefetchReqCnt         : current unrequested prefetched blocks
//   almostFull             : data queue almost full
//   pref_valid/ready/addr  : prefetch request handshake (opcode readReqPref downstream)
//   locked                 : high in LOCKED and DRAIN
//   stride                 : current signed stride
module prefetch_stride_detector
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 64,
  parameter int unsigned STRIDE_WIDTH   = 16,
  parameter int unsigned LOG_QUEUE_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           obs_valid,
  input  logic        [ADDR_BITS-1:0]    obs_addr,
  input  logic                           crs_enable,
  input  logic        [1:0]              crs_confThreshold,
  input  logic        [LOG_QUEUE_SIZE:0] crs_prefetchDepth,
  input  logic        [LOG_QUEUE_SIZE:0] prefetchReqCnt,
  input  logic                           almostFull,
  output logic                           pref_valid,
  input  logic                           pref_ready,
  output logic        [ADDR_BITS-1:0]    pref_addr,
  output logic                           locked,
  output logic signed [STRIDE_WIDTH-1:0] stride
);

  det_state_e                     state_q, state_d;
  logic        [ADDR_BITS-1:0]    last_addr_q, last_addr_d;
  logic        [ADDR_BITS-1:0]    next_addr_q, next_addr_d;
  logic        [ADDR_BITS-1:0]    pref_addr_q, pref_addr_d;
  logic                           pref_valid_q, pref_valid_d;
  logic                           locked_q, locked_d;
  logic signed [STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic        [ConfWidth-1:0]    conf_q, conf_d;

  logic signed [STRIDE_WIDTH-1:0] delta;
  logic                           in_range;
  logic                           match;

  logic [ADDR_BITS-1:0] stride_ext;
  logic [ADDR_BITS-1:0] resync_addr;
  logic [ADDR_BITS-1:0] resync_diff;
  logic                 resync_ahead;
  logic                 accept;
  logic                 pend_after;
  logic                 can_issue;
  logic [1:0]           thr_eff;
  logic [1:0]           conf_inc;
  logic                 lock_hit;
  logic signed [STRIDE_WIDTH-1:0] train_stride;

  prefetch_stride_calc #(
    .ADDR_BITS    (ADDR_BITS),
    .STRIDE_WIDTH (STRIDE_WIDTH)
  ) u_calc (
    .obs_addr_i  (obs_addr),
    .last_addr_i (last_addr_q),
    .stride_i    (stride_q),
    .delta_o     (delta),
    .in_range_o  (in_range),
    .match_o     (match)
  );

  always_comb begin
    stride_ext   = {{(ADDR_BITS-STRIDE_WIDTH){stride_q[STRIDE_WIDTH-1]}}, stride_q};
    resync_addr  = obs_addr + stride_ext;
    resync_diff  = resync_addr - next_addr_q;
    // Ahead along the stride direction: difference nonzero with the same sign as stride.
    resync_ahead = (resync_diff != '0) &&
                   (resync_diff[ADDR_BITS-1] == stride_q[STRIDE_WIDTH-1]);
    accept       = pref_valid_q && pref_ready;
    pend_after   = pref_valid_q && !pref_ready;
    can_issue    = !almostFull && (prefetchReqCnt < crs_prefetchDepth);
    thr_eff      = eff_threshold(crs_confThreshold);
    conf_inc     = (conf_q == ConfMax) ? ConfMax : conf_q + 2'd1;
    // conf counts repeats of the stride; the delta that established the stride is one
    // more matching delta, so the total after this match is conf_q + 2.
    lock_hit     = ({1'b0, conf_q} + 3'd2) >= {1'b0, thr_eff};
    train_stride = in_range ? delta : '0;
  end

  always_comb begin
    state_d      = state_q;
    last_addr_d  = last_addr_q;
    next_addr_d  = next_addr_q;
    pref_addr_d  = pref_addr_q;
    pref_valid_d = pref_valid_q;
    stride_d     = stride_q;
    conf_d       = conf_q;

    unique case (state_q)
      StIdle: begin
        if (crs_enable && obs_valid) begin
          last_addr_d = obs_addr;
          conf_d      = '0;
          state_d     = StTrain;
        end
      end

      StTrain: begin
        if (!crs_enable) begin
          conf_d  = '0;
          state_d = StIdle;
        end else if (obs_valid) begin
          last_addr_d = obs_addr;
          if (match) begin
            conf_d = conf_inc;
            if (lock_hit) begin
              next_addr_d = resync_addr;
              state_d     = StLocked;
            end
          end else begin
            stride_d = train_stride;
            conf_d   = '0;
          end
        end
      end

      StLocked: begin
        if (!crs_enable) begin
          conf_d       = '0;
          pref_valid_d = pend_after;
          state_d      = pend_after ? StDrain : StIdle;
        end else if (obs_valid && !match) begin
          stride_d     = train_stride;
          conf_d       = '0;
          last_addr_d  = obs_addr;
          pref_valid_d = pend_after;
          state_d      = pend_after ? StDrain : StTrain;
        end else begin
          if (accept) begin
            next_addr_d = next_addr_q + stride_ext;
          end
          // A confirming observation that overtakes the prefetch stream wins over the
          // handshake increment.
          if (obs_valid) begin
            last_addr_d = obs_addr;
            if (resync_ahead) begin
              next_addr_d = resync_addr;
            end
          end
          // A pending request is frozen until accepted; only then may a new one load.
          if (!pref_valid_q || accept) begin
            pref_valid_d = can_issue;
            if (can_issue) begin
              pref_addr_d = next_addr_d;
            end
          end
        end
      end

      StDrain: begin
        if (crs_enable && obs_valid) begin
          last_addr_d = obs_addr;
          if (match) begin
            conf_d = conf_inc;
          end else begin
            stride_d = train_stride;
            conf_d   = '0;
          end
        end else if (!crs_enable) begin
          conf_d = '0;
        end
        if (accept || !pref_valid_q) begin
          pref_valid_d = 1'b0;
          state_d      = crs_enable ? StTrain : StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    locked_d = (state_d == StLocked) || (state_d == StDrain);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      last_addr_q  <= '0;
      next_addr_q  <= '0;
      pref_addr_q  <= '0;
      pref_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      stride_q     <= '0;
      conf_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_addr_q  <= last_addr_d;
      next_addr_q  <= next_addr_d;
      pref_addr_q  <= pref_addr_d;
      pref_valid_q <= pref_valid_d;
      locked_q     <= locked_d;
      stride_q     <= stride_d;
      conf_q       <= conf_d;
    end
  end

  assign pref_valid = pref_valid_q;
  assign pref_addr  = pref_addr_q;
  assign locked     = locked_q;
  assign stride     = stride_q;

endmodule
